adc_capture_buffer: RTL and testbench
=====================================

Name: adc_capture_buffer

Overview:
Parameterised capture-and-forward buffer between the SPI ADC reader and the Arduino serial writer. On `arm` it stores a runtime-selected number of ADC samples, with optional decimation, into an internal buffer. It then hands the samples one at a time, oldest first, to the writer using a start/busy handshake. It supports one-shot and continuous (auto-rearm) operation and generalises the fixed 8 × 12-bit collector.

Parameters:
- SAMPLE_W, 12: ADC sample width in bits.
- DEPTH, 12: buffer capacity in samples.
- CNT_W, 4: counter width. Must satisfy 2^CNT_W > DEPTH.
- DECIM_W, 4: width of the decimation factor.

Ports:
- clk, input, 1: 50 MHz system clock.
- rst, input, 1: asynchronous, active-high reset.
- arm, input, 1: one-cycle request to start a capture. Honoured only in IDLE.
- continuous, input, 1: 1 = re-enter COLLECT automatically after DONE. Sampled every cycle in DONE.
- limit, input, CNT_W: samples per capture. Latched at arm.
- decim, input, DECIM_W: keep one of every decim+1 accepted strobes. Latched at arm.
- adc_valid, input, 1: one-cycle strobe marking a new adc_sample.
- adc_sample, input, SAMPLE_W: ADC conversion result. Valid when adc_valid=1.
- tx_busy, input, 1: writer is transmitting.
- tx_start, output, 1: one-cycle pulse requesting the writer to send tx_sample.
- tx_sample, output, SAMPLE_W: sample being transmitted.
- collected, output, CNT_W: samples stored in the current capture.
- transmitted, output, CNT_W: samples completed in the current capture.
- busy, output, 1: high in every state except IDLE.
- done, output, 1: one-cycle pulse when a capture has been fully transmitted.
- overrun, output, 1: sticky flag for ADC strobes that arrived while the block was transmitting.

Behaviour:
- Reset (rst=1, asynchronous):
  - state=IDLE; tx_start=0, tx_sample=0, collected=0, transmitted=0, busy=0, done=0, overrun=0.
  - Decimation counter=0. Buffer contents are don't-care.
- States: IDLE, COLLECT, TX_START, TX_WAIT_HI, TX_WAIT_LO, DONE.
- IDLE:
  - On arm=1: latch L and D, clear collected, transmitted, overrun and the decimation counter, go COLLECT.
  - L = DEPTH if limit=0 or limit>DEPTH, else limit. D = decim.
- COLLECT, on each adc_valid=1:
  - If decimation counter=0: write adc_sample to buffer[collected], collected+1.
  - Then decimation counter = (counter==D) ? 0 : counter+1.
  - D=0 stores every strobe. D=3 stores strobes 1, 5, 9, …
  - The strobe that makes collected reach L moves the state to TX_START on the next edge.
  - adc_valid in any other state is never stored.
- TX_START:
  - tx_sample=buffer[transmitted]; tx_start=1 for exactly this one cycle.
  - Next state TX_WAIT_HI.
- TX_WAIT_HI: wait for tx_busy=1, then go TX_WAIT_LO.
- TX_WAIT_LO:
  - On tx_busy=0: transmitted+1.
  - If the new count equals L go DONE, else go TX_START.
  - tx_sample holds its value from TX_START through TX_WAIT_LO.
- Latency:
  - Collect-complete strobe to first tx_start: 1 cycle.
  - tx_busy falling to the next tx_start: 2 cycles.
- DONE:
  - done=1 for one cycle.
  - If continuous=1: clear collected, transmitted and the decimation counter; re-latch L and D from the inputs; go COLLECT.
  - If continuous=0: go IDLE. collected and transmitted keep their final values until the next arm.
- overrun:
  - Set when adc_valid=1 in TX_START, TX_WAIT_HI, TX_WAIT_LO or DONE while continuous=1.
  - Held until rst or an accepted arm.
  - Never set in one-shot mode.
- Ordering: samples are sent FIFO, buffer[0] first. Buffer locations at and above L are never read.
- arm outside IDLE is ignored, including in DONE and while transmitting.
- rst asserted mid-capture or mid-transmit aborts immediately. tx_start drops in the same instant.

Test Plan:
- One-shot capture: limit=8, decim=0, continuous=0; arm, then 8 strobes carrying samples 0x001..0x008; writer model holds busy for 40 cycles per sample.
  - Required: 8 tx_start pulses carrying 0x001..0x008 in order, then one done pulse, then IDLE.
  - Required: collected=8 and transmitted=8 at the end; overrun=0.
- Decimation: decim=2, limit=4; strobes carry 0x100..0x10B.
  - Required: stored and sent values are 0x100, 0x103, 0x106, 0x109.
- Limit clamp: limit=0, then limit=15 with DEPTH=12.
  - Required: both captures store and send exactly 12 samples.
- Continuous and overrun: continuous=1, limit=2; strobes keep arriving during transmit.
  - Required: overrun=1 after the first transmit; a second capture starts automatically after done.
  - Required: arm during the transmit is ignored; overrun clears only on a new accepted arm after continuous is dropped.
- Reset mid-transmit: assert rst while the block is in TX_WAIT_LO.
  - Required: every output returns to its reset value with no further tx_start.
  - Required: a subsequent arm runs a complete capture normally.

Source files
------------

// File: rtl/adc_capture_buffer.sv
// Capture-and-forward buffer between the SPI ADC reader and the serial writer:
// collects a latched number of (optionally decimated) samples, then hands them out oldest first.
module adc_capture_buffer #(
   parameter int SAMPLE_W = 12,
   parameter int DEPTH    = 12,
   parameter int CNT_W    = 4,
   parameter int DECIM_W  = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                arm,
   input  logic                continuous,
   input  logic [CNT_W-1:0]    limit,
   input  logic [DECIM_W-1:0]  decim,
   input  logic                adc_valid,
   input  logic [SAMPLE_W-1:0] adc_sample,
   input  logic                tx_busy,
   output logic                tx_start,
   output logic [SAMPLE_W-1:0] tx_sample,
   output logic [CNT_W-1:0]    collected,
   output logic [CNT_W-1:0]    transmitted,
   output logic                busy,
   output logic                done,
   output logic                overrun
);

   // state        | meaning
   // S_IDLE       | waiting for arm
   // S_COLLECT    | storing decimated ADC strobes until L samples held
   // S_TX_START   | tx_start pulse with tx_sample = buffer[transmitted]
   // S_TX_WAIT_HI | waiting for the writer to raise tx_busy
   // S_TX_WAIT_LO | waiting for the writer to finish the sample
   // S_DONE       | done pulse, then re-collect (continuous) or return to idle
   typedef enum logic [2:0] {
      S_IDLE,
      S_COLLECT,
      S_TX_START,
      S_TX_WAIT_HI,
      S_TX_WAIT_LO,
      S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   function automatic logic [CNT_W-1:0] clamp_limit(input logic [CNT_W-1:0] l);
      return ((l == '0) || (l > DEPTH_C)) ? DEPTH_C : l;
   endfunction

   logic [SAMPLE_W-1:0] mem [DEPTH];
   state_t              state;
   logic [CNT_W-1:0]    lim;
   logic [DECIM_W-1:0]  dec;
   logic [DECIM_W-1:0]  dcnt;
   logic                busy_q;
   logic                keep;
   logic                wr_en;
   logic [CNT_W-1:0]    coll_next;
   logic [CNT_W-1:0]    tx_next;
   logic                tx_phase;

   assign keep      = adc_valid && (dcnt == '0);
   assign wr_en     = (state == S_COLLECT) && keep;
   assign coll_next = collected + 1'b1;
   assign tx_next   = transmitted + 1'b1;
   assign tx_phase  = (state == S_TX_START) || (state == S_TX_WAIT_HI) ||
                      (state == S_TX_WAIT_LO) || (state == S_DONE);

   // Sample storage carries no reset; contents are only read below the latched limit.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[collected] <= adc_sample;
      end
   end

   // The writer's busy comes from another block; one register stage isolates it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= 1'b0;
      end else begin
         busy_q <= tx_busy;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         tx_start    <= 1'b0;
         tx_sample   <= '0;
         collected   <= '0;
         transmitted <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         overrun     <= 1'b0;
         dcnt        <= '0;
         lim         <= '0;
         dec         <= '0;
      end else begin
         tx_start <= 1'b0;
         done     <= 1'b0;

         if (adc_valid && continuous && tx_phase) begin
            overrun <= 1'b1;
         end

         case (state)
            S_IDLE: begin
               if (arm) begin
                  lim         <= clamp_limit(limit);
                  dec         <= decim;
                  collected   <= '0;
                  transmitted <= '0;
                  overrun     <= 1'b0;
                  dcnt        <= '0;
                  busy        <= 1'b1;
                  state       <= S_COLLECT;
               end
            end

            S_COLLECT: begin
               if (adc_valid) begin
                  dcnt <= (dcnt == dec) ? '0 : dcnt + 1'b1;
                  if (keep) begin
                     collected <= coll_next;
                     if (coll_next == lim) begin
                        // With a one-sample capture, buffer[0] is being written this edge.
                        tx_sample <= (collected == '0) ? adc_sample : mem[0];
                        tx_start  <= 1'b1;
                        state     <= S_TX_START;
                     end
                  end
               end
            end

            S_TX_START: begin
               state <= S_TX_WAIT_HI;
            end

            S_TX_WAIT_HI: begin
               if (busy_q) begin
                  state <= S_TX_WAIT_LO;
               end
            end

            S_TX_WAIT_LO: begin
               if (!busy_q) begin
                  transmitted <= tx_next;
                  if (tx_next == lim) begin
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     tx_sample <= mem[tx_next];
                     tx_start  <= 1'b1;
                     state     <= S_TX_START;
                  end
               end
            end

            S_DONE: begin
               if (continuous) begin
                  collected   <= '0;
                  transmitted <= '0;
                  dcnt        <= '0;
                  lim         <= clamp_limit(limit);
                  dec         <= decim;
                  state       <= S_COLLECT;
               end else begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            end

            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adc_capture_buffer.sv
// Self-checking bench for adc_capture_buffer: table-driven captures, random captures
// against a list model, plus continuous/overrun and reset-abort sequences.
module tb_adc_capture_buffer;

   localparam int DEPTH = 12;

   logic        clk;
   logic        rst;
   logic        arm;
   logic        continuous;
   logic [3:0]  limit;
   logic [3:0]  decim;
   logic        adc_valid;
   logic [11:0] adc_sample;
   logic        tx_busy;
   logic        tx_start;
   logic [11:0] tx_sample;
   logic [3:0]  collected;
   logic [3:0]  transmitted;
   logic        busy;
   logic        done;
   logic        overrun;

   adc_capture_buffer #(
      .SAMPLE_W(12),
      .DEPTH(DEPTH),
      .CNT_W(4),
      .DECIM_W(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .arm(arm),
      .continuous(continuous),
      .limit(limit),
      .decim(decim),
      .adc_valid(adc_valid),
      .adc_sample(adc_sample),
      .tx_busy(tx_busy),
      .tx_start(tx_start),
      .tx_sample(tx_sample),
      .collected(collected),
      .transmitted(transmitted),
      .busy(busy),
      .done(done),
      .overrun(overrun)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   typedef struct {
      int lim;
      int dec;
      int base;
      int hold;
      int exp_n;
      int exp_first;
      int exp_step;
   } vec_t;

   int          checks;
   int          errors;
   int          cyc;
   logic [11:0] got[$];
   int          done_cnt;
   int          fall_cyc;
   bit          seen_start;
   bit          seen_done;
   bit          w_pending;
   bit          w_rnd;
   int          w_wait;
   int          w_hold;
   int          hold_cfg;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock: sample outputs at negedge, then advance the writer model.
   task automatic step();
      @(negedge clk);
      cyc++;
      seen_start = tx_start;
      seen_done  = done;
      if (tx_start) begin
         got.push_back(tx_sample);
         w_pending = 1'b1;
         w_wait    = w_rnd ? int'($urandom_range(0, 3)) : 0;
      end
      if (done) done_cnt++;
      if (w_pending) begin
         if (w_wait == 0) begin
            tx_busy   = 1'b1;
            w_hold    = w_rnd ? int'($urandom_range(1, hold_cfg)) : hold_cfg;
            w_pending = 1'b0;
         end else begin
            w_wait--;
         end
      end else if (tx_busy) begin
         if (w_hold <= 1) begin
            tx_busy  = 1'b0;
            fall_cyc = cyc;
         end else begin
            w_hold--;
         end
      end
   endtask

   // One-shot capture; strobe i carries base+i, expected sample k is exp_first+k*exp_step.
   task automatic run_capture(input int lim_in, input int dec_in, input int base, input int hold,
                              input bit rnd, input int exp_n, input int exp_first, input int exp_step);
      logic [11:0] exp_q[$];
      int          strobe_idx;
      int          first_cyc;
      int          budget;
      bit          fin;
      for (int k = 0; k < exp_n; k++) exp_q.push_back(12'(exp_first + k * exp_step));
      got.delete();
      done_cnt   = 0;
      hold_cfg   = hold;
      w_rnd      = rnd;
      first_cyc  = -1;
      strobe_idx = 0;
      continuous = 1'b0;
      step();
      arm   = 1'b1;
      limit = 4'(lim_in);
      decim = 4'(dec_in);
      step();
      arm = 1'b0;
      chk("armed_busy", busy, 1);
      chk("armed_overrun", overrun, 0);
      chk("armed_collected", collected, 0);
      fin    = 1'b0;
      budget = 0;
      while (!fin && budget < 4000) begin
         adc_valid = rnd ? ($urandom_range(0, 2) == 0) : (budget % 2 == 0);
         if (adc_valid) begin
            adc_sample = 12'(base + strobe_idx);
            if (strobe_idx == (exp_n - 1) * exp_step) first_cyc = cyc + 1;
            strobe_idx++;
         end
         step();
         budget++;
         if (seen_start) chk("tx_start_cycle", cyc, (got.size() == 1) ? first_cyc : fall_cyc + 2);
         if (seen_done) begin
            chk("done_cycle", cyc, fall_cyc + 2);
            fin = 1'b1;
         end
      end
      adc_valid = 1'b0;
      chk("capture_finished", fin, 1);
      step();
      chk("end_busy", busy, 0);
      chk("end_collected", collected, exp_n);
      chk("end_transmitted", transmitted, exp_n);
      chk("end_overrun", overrun, 0);
      chk("done_pulses", done_cnt, 1);
      chk("sent_count", got.size(), exp_n);
      for (int k = 0; k < exp_n && k < got.size(); k++) chk("sample_value", got[k], exp_q[k]);
   endtask

   task automatic seq_continuous();
      int j;
      int t0;
      int arm_cyc;
      int d1c;
      int starts_at_d1;
      int budget;
      bit armed_tx;
      got.delete();
      done_cnt     = 0;
      hold_cfg     = 6;
      w_rnd        = 1'b0;
      t0           = -100;
      arm_cyc      = -100;
      d1c          = -100;
      starts_at_d1 = 0;
      armed_tx     = 1'b0;
      step();
      continuous = 1'b1;
      limit      = 4'd2;
      decim      = 4'd0;
      arm        = 1'b1;
      step();
      arm    = 1'b0;
      j      = 0;
      budget = 0;
      while (done_cnt < 2 && budget < 2000) begin
         adc_valid  = (j % 2 == 0);
         adc_sample = 12'(12'h700 + j / 2);
         j++;
         if (got.size() == 1 && !armed_tx && cyc == t0 + 3) begin
            arm      = 1'b1;
            armed_tx = 1'b1;
            arm_cyc  = cyc;
         end
         step();
         arm = 1'b0;
         budget++;
         if (seen_start && got.size() == 1) t0 = cyc;
         if (cyc == arm_cyc + 1) begin
            chk("tx_arm_busy", busy, 1);
            chk("tx_arm_overrun_kept", overrun, 1);
            chk("tx_arm_collected_kept", collected, 2);
         end
         if (seen_done && done_cnt == 1) begin
            chk("cont_overrun_after_tx", overrun, 1);
            chk("cont_first_len", got.size(), 2);
            starts_at_d1 = got.size();
            d1c          = cyc;
            limit        = 4'd3;
         end
         if (cyc == d1c + 1) begin
            chk("cont_rearm_busy", busy, 1);
            chk("cont_rearm_collected", collected, 0);
         end
         if (seen_done && done_cnt == 2) begin
            chk("cont_second_len", got.size() - starts_at_d1, 3);
            continuous = 1'b0;
         end
      end
      adc_valid = 1'b0;
      chk("cont_two_dones", done_cnt, 2);
      chk("cont_arm_seen", armed_tx, 1);
      if (got.size() >= 2) begin
         chk("cont_sample0", got[0], 12'h700);
         chk("cont_sample1", got[1], 12'h701);
      end
      step();
      chk("cont_idle_busy", busy, 0);
      chk("cont_overrun_held", overrun, 1);
      chk("cont_final_collected", collected, 3);
      chk("cont_final_transmitted", transmitted, 3);
   endtask

   task automatic seq_reset_mid_tx();
      int b;
      int n;
      got.delete();
      hold_cfg = 40;
      w_rnd    = 1'b0;
      step();
      continuous = 1'b0;
      limit      = 4'd3;
      decim      = 4'd0;
      arm        = 1'b1;
      step();
      arm = 1'b0;
      for (int i = 0; i < 3; i++) begin
         adc_valid  = 1'b1;
         adc_sample = 12'(12'h900 + i);
         step();
      end
      adc_valid = 1'b0;
      b = 0;
      while (got.size() == 0 && b < 50) begin
         step();
         b++;
      end
      chk("rst_seq_started", got.size(), 1);
      repeat (5) step();
      #2 rst = 1'b1;
      #1;
      chk("rst_tx_start", tx_start, 0);
      chk("rst_tx_sample", tx_sample, 0);
      chk("rst_collected", collected, 0);
      chk("rst_transmitted", transmitted, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_overrun", overrun, 0);
      tx_busy   = 1'b0;
      w_pending = 1'b0;
      n = got.size();
      repeat (3) step();
      chk("rst_no_tx_start", got.size(), n);
      rst = 1'b0;
      step();
      chk("post_rst_idle", busy, 0);
   endtask

   initial begin
      vec_t vecs[7];
      int   lim_r;
      int   dec_r;
      int   l_model;
      int   base_r;
      vecs[0] = '{lim: 8,  dec: 0, base: 12'h001, hold: 40, exp_n: 8,  exp_first: 12'h001, exp_step: 1};
      vecs[1] = '{lim: 4,  dec: 2, base: 12'h100, hold: 5,  exp_n: 4,  exp_first: 12'h100, exp_step: 3};
      vecs[2] = '{lim: 0,  dec: 0, base: 12'h200, hold: 3,  exp_n: 12, exp_first: 12'h200, exp_step: 1};
      vecs[3] = '{lim: 15, dec: 0, base: 12'h300, hold: 3,  exp_n: 12, exp_first: 12'h300, exp_step: 1};
      vecs[4] = '{lim: 1,  dec: 0, base: 12'h050, hold: 4,  exp_n: 1,  exp_first: 12'h050, exp_step: 1};
      vecs[5] = '{lim: 12, dec: 3, base: 12'h400, hold: 2,  exp_n: 12, exp_first: 12'h400, exp_step: 4};
      vecs[6] = '{lim: 13, dec: 1, base: 12'h500, hold: 2,  exp_n: 12, exp_first: 12'h500, exp_step: 2};

      checks     = 0;
      errors     = 0;
      cyc        = 0;
      done_cnt   = 0;
      fall_cyc   = 0;
      w_pending  = 1'b0;
      w_rnd      = 1'b0;
      w_wait     = 0;
      w_hold     = 0;
      hold_cfg   = 1;
      rst        = 1'b1;
      arm        = 1'b0;
      continuous = 1'b0;
      limit      = 4'd0;
      decim      = 4'd0;
      adc_valid  = 1'b0;
      adc_sample = 12'd0;
      tx_busy    = 1'b0;

      repeat (3) step();
      chk("reset_tx_start", tx_start, 0);
      chk("reset_tx_sample", tx_sample, 0);
      chk("reset_collected", collected, 0);
      chk("reset_transmitted", transmitted, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_overrun", overrun, 0);
      rst = 1'b0;

      for (int v = 0; v < 7; v++) begin
         run_capture(vecs[v].lim, vecs[v].dec, vecs[v].base, vecs[v].hold, 1'b0,
                     vecs[v].exp_n, vecs[v].exp_first, vecs[v].exp_step);
      end

      seq_continuous();
      run_capture(2, 0, 12'h600, 3, 1'b0, 2, 12'h600, 1);

      seq_reset_mid_tx();
      run_capture(3, 0, 12'h900, 5, 1'b0, 3, 12'h900, 1);

      for (int r = 0; r < 12; r++) begin
         lim_r   = int'($urandom_range(0, 15));
         dec_r   = int'($urandom_range(0, 3));
         base_r  = int'($urandom_range(0, 12'hE00));
         l_model = (lim_r == 0 || lim_r > DEPTH) ? DEPTH : lim_r;
         run_capture(lim_r, dec_r, base_r, 12, 1'b1, l_model, base_r, dec_r + 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
